// File: rtl/dyn_bpu_pkg.sv
// Shared configuration for the dynamic branch predictor: opcodes, widths,
// 2-bit counter encodings and the saturating counter step.
package dyn_bpu_pkg;

    localparam int          XLEN          = 32;
    localparam logic [6:0]  OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0]  OPCODE_BREACH = 7'b1100011;
    localparam logic [31:0] ZERO_32BIT    = 32'h0000_0000;
    localparam logic [31:0] STAT_MAX      = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    typedef enum logic [1:0] {
        INS_OTHER  = 2'd0,
        INS_JAL    = 2'd1,
        INS_BRANCH = 2'd2
    } ins_kind_t;

    // Saturating up/down step of a 2-bit direction counter.
    function automatic ctr_t ctr_step(ctr_t c, logic taken);
        ctr_t n;
        n = c;
        if (taken) begin
            if (c != ST) n = ctr_t'(c + 2'd1);
        end else begin
            if (c != SNT) n = ctr_t'(c - 2'd1);
        end
        return n;
    endfunction

endpackage

// File: rtl/dyn_bpu_if.sv
// Port bundle between the predictor core and its branch history table:
// one combinational read port and one clocked write port.
interface dyn_bpu_if #(
    parameter int IDX_W = 6
);
    import dyn_bpu_pkg::*;

    logic [IDX_W-1:0] rd_idx;
    ctr_t             rd_ctr;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic             wr_taken;

    modport master (
        output rd_idx,
        output wr_en,
        output wr_idx,
        output wr_taken,
        input  rd_ctr
    );

    modport slave (
        input  rd_idx,
        input  wr_en,
        input  wr_idx,
        input  wr_taken,
        output rd_ctr
    );

endinterface

// File: rtl/dyn_bpu_bht.sv
// Branch history table: BHT_DEPTH saturating 2-bit counters with an
// asynchronous reset to BHT_INIT, zero-latency read and edge-triggered update.
module bpu_bht
    import dyn_bpu_pkg::*;
#(
    parameter int         BHT_DEPTH = 64,
    parameter logic [1:0] BHT_INIT  = 2'b01
) (
    input  logic         clk,
    input  logic         rst_n,
    dyn_bpu_if.slave     bht
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    ctr_t ctr_vec [BHT_DEPTH];

    // Per-entry registers so the whole table clears asynchronously; a read
    // during a same-index write sees the old value (no bypass).
    generate
        for (genvar gi = 0; gi < BHT_DEPTH; gi++) begin : g_entry
            ctr_t ctr_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ctr_reg <= ctr_t'(BHT_INIT);
                end else if (bht.wr_en && (bht.wr_idx == IDX_W'(gi))) begin
                    ctr_reg <= ctr_step(ctr_reg, bht.wr_taken);
                end
            end

            assign ctr_vec[gi] = ctr_reg;
        end
    endgenerate

    assign bht.rd_ctr = ctr_vec[bht.rd_idx];

endmodule

// File: rtl/dyn_bpu.sv
// Dynamic branch predictor: decodes the fetched word, forms the target and
// chooses the next PC from a 2-bit BHT; also keeps resolved-branch statistics.
module dyn_bpu #(
    parameter int         XLEN      = dyn_bpu_pkg::XLEN,
    parameter int         BHT_DEPTH = 64,
    parameter logic [1:0] BHT_INIT  = 2'b01
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] instruction,
    input  logic            flush_flag,
    input  logic [XLEN-1:0] flush_addr,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic            upd_mispred,
    output logic [XLEN-1:0] pc_pred,
    output logic            pred_taken,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispreds
);
    import dyn_bpu_pkg::*;

    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [6:0]      opcode;
    ins_kind_t       kind;
    logic [XLEN-1:0] imm_jal;
    logic [XLEN-1:0] imm_br;
    logic [XLEN-1:0] imm;
    logic [31:0]     stat_branches_reg;
    logic [31:0]     stat_mispreds_reg;

    dyn_bpu_if #(.IDX_W(IDX_W)) bht_bus ();

    bpu_bht #(
        .BHT_DEPTH (BHT_DEPTH),
        .BHT_INIT  (BHT_INIT)
    ) u_bht (
        .clk   (clk),
        .rst_n (rst_n),
        .bht   (bht_bus)
    );

    // Word-aligned PCs: bits [1:0] carry no information for indexing.
    assign bht_bus.rd_idx   = pc[IDX_W+1:2];
    assign bht_bus.wr_en    = upd_valid;
    assign bht_bus.wr_idx   = upd_pc[IDX_W+1:2];
    assign bht_bus.wr_taken = upd_taken;

    assign opcode  = instruction[6:0];
    assign imm_jal = {{(XLEN-20){instruction[31]}}, instruction[19:12],
                      instruction[20], instruction[30:21], 1'b0};
    assign imm_br  = {{(XLEN-12){instruction[31]}}, instruction[7],
                      instruction[30:25], instruction[11:8], 1'b0};

    always_comb begin
        kind = INS_OTHER;
        imm  = XLEN'(ZERO_32BIT);
        case (opcode)
            OPCODE_JAL: begin
                kind = INS_JAL;
                imm  = imm_jal;
            end
            OPCODE_BREACH: begin
                kind = INS_BRANCH;
                imm  = imm_br;
            end
            default: begin
                kind = INS_OTHER;
                imm  = XLEN'(ZERO_32BIT);
            end
        endcase
    end

    // Flush only redirects the PC; pred_taken still reflects the decode.
    always_comb begin
        pred_taken = (kind == INS_JAL) ||
                     ((kind == INS_BRANCH) && bht_bus.rd_ctr[1]);
        pc_pred    = pc + XLEN'(4);
        if (flush_flag) begin
            pc_pred = flush_addr;
        end else if (pred_taken) begin
            pc_pred = pc + imm;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches_reg <= '0;
            stat_mispreds_reg <= '0;
        end else if (upd_valid) begin
            if (stat_branches_reg != STAT_MAX) begin
                stat_branches_reg <= stat_branches_reg + 32'd1;
            end
            if (upd_mispred && (stat_mispreds_reg != STAT_MAX)) begin
                stat_mispreds_reg <= stat_mispreds_reg + 32'd1;
            end
        end
    end

    assign stat_branches = stat_branches_reg;
    assign stat_mispreds = stat_mispreds_reg;

    logic unused_bits;
    assign unused_bits = ^{upd_pc[XLEN-1:IDX_W+2], upd_pc[1:0], bht_bus.rd_ctr[0]};

endmodule

// File: tb/tb_dyn_bpu.sv
// Directed bench for dyn_bpu: a 64-entry and a 128-entry instance share the
// stimulus and are compared every cycle against an arithmetic model.
module tb_dyn_bpu;

    localparam logic [31:0] BR_M8   = 32'hFE000CE3; // beq x0,x0,-8
    localparam logic [31:0] JAL_800 = 32'h0010006F; // jal x0,+0x800

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc, instruction, flush_addr, upd_pc;
    logic        flush_flag, upd_valid, upd_taken, upd_mispred;

    logic [31:0] pc_pred64, pc_pred128;
    logic        pred_taken64, pred_taken128;
    logic [31:0] stat_br64, stat_mp64, stat_br128, stat_mp128;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    int     m64  [64];
    int     m128 [128];
    longint m_br, m_mp;

    always #5 clk = ~clk;

    dyn_bpu #(.XLEN(32), .BHT_DEPTH(64), .BHT_INIT(2'b01)) dut64 (
        .clk(clk), .rst_n(rst_n), .pc(pc), .instruction(instruction),
        .flush_flag(flush_flag), .flush_addr(flush_addr),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_mispred(upd_mispred), .pc_pred(pc_pred64), .pred_taken(pred_taken64),
        .stat_branches(stat_br64), .stat_mispreds(stat_mp64)
    );

    dyn_bpu #(.XLEN(32), .BHT_DEPTH(128), .BHT_INIT(2'b01)) dut128 (
        .clk(clk), .rst_n(rst_n), .pc(pc), .instruction(instruction),
        .flush_flag(flush_flag), .flush_addr(flush_addr),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_mispred(upd_mispred), .pc_pred(pc_pred128), .pred_taken(pred_taken128),
        .stat_branches(stat_br128), .stat_mispreds(stat_mp128)
    );

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Target offset computed from the instruction fields by plain arithmetic.
    function automatic longint imm_of(input logic [31:0] ins);
        longint v;
        v = 0;
        if (ins[6:0] == 7'h6F) begin
            v = longint'(ins[30:21]) * 2 + longint'(ins[20]) * 2048 + longint'(ins[19:12]) * 4096;
            if (ins[31]) v = v - 1048576;
        end else if (ins[6:0] == 7'h63) begin
            v = longint'(ins[11:8]) * 2 + longint'(ins[30:25]) * 32 + longint'(ins[7]) * 2048;
            if (ins[31]) v = v - 4096;
        end
        return v;
    endfunction

    function automatic bit exp_taken(input logic [31:0] ins, input int ctr);
        return (ins[6:0] == 7'h6F) || ((ins[6:0] == 7'h63) && (ctr >= 2));
    endfunction

    function automatic longint exp_pc(input logic [31:0] p, input logic [31:0] ins,
                                      input logic fl, input logic [31:0] fa, input int ctr);
        longint t;
        if (fl) return longint'(fa);
        if (exp_taken(ins, ctr)) t = longint'(p) + imm_of(ins);
        else                     t = longint'(p) + 4;
        return t & 64'hFFFF_FFFF;
    endfunction

    // Reference state: counters as integers 0..3, statistics as wide integers.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            foreach (m64[i])  m64[i]  <= 1;
            foreach (m128[i]) m128[i] <= 1;
            m_br <= 0;
            m_mp <= 0;
        end else if (upd_valid) begin
            m64[(upd_pc / 4) % 64] <= upd_taken ?
                ((m64[(upd_pc / 4) % 64] < 3) ? m64[(upd_pc / 4) % 64] + 1 : 3) :
                ((m64[(upd_pc / 4) % 64] > 0) ? m64[(upd_pc / 4) % 64] - 1 : 0);
            m128[(upd_pc / 4) % 128] <= upd_taken ?
                ((m128[(upd_pc / 4) % 128] < 3) ? m128[(upd_pc / 4) % 128] + 1 : 3) :
                ((m128[(upd_pc / 4) % 128] > 0) ? m128[(upd_pc / 4) % 128] - 1 : 0);
            m_br <= (m_br < 64'hFFFF_FFFF) ? m_br + 1 : m_br;
            if (upd_mispred) m_mp <= (m_mp < 64'hFFFF_FFFF) ? m_mp + 1 : m_mp;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("pc_pred64",  pc_pred64,
                  exp_pc(pc, instruction, flush_flag, flush_addr, m64[(pc / 4) % 64]));
            check("pred_taken64", pred_taken64, exp_taken(instruction, m64[(pc / 4) % 64]));
            check("pc_pred128", pc_pred128,
                  exp_pc(pc, instruction, flush_flag, flush_addr, m128[(pc / 4) % 128]));
            check("pred_taken128", pred_taken128, exp_taken(instruction, m128[(pc / 4) % 128]));
            check("stat_branches", stat_br64, m_br);
            check("stat_mispreds", stat_mp64, m_mp);
            check("stat_branches128", stat_br128, m_br);
            check("stat_mispreds128", stat_mp128, m_mp);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_upd(input logic v, input logic [31:0] p, input logic t, input logic m);
        upd_valid = v; upd_pc = p; upd_taken = t; upd_mispred = m;
    endtask

    logic [31:0] tbl_pc  [6] = '{32'h40, 32'h10, 32'h0, 32'h300, 32'h204, 32'h104};
    logic [31:0] tbl_ins [6] = '{32'h00100093, 32'hFFDFF06F, 32'hFFDFF06F,
                                 32'h00000863, BR_M8, 32'h00000863};

    initial begin
        rst_n = 1'b0; pc = 32'h100; instruction = BR_M8;
        flush_flag = 1'b0; flush_addr = '0;
        set_upd(1'b0, '0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;
        #1;
        check("reset_pc_pred",    pc_pred64, 32'h104);
        check("reset_pred_taken", pred_taken64, 0);
        rst_n = 1'b1;
        tick();

        set_upd(1'b1, 32'h100, 1'b1, 1'b1); tick();
        set_upd(1'b1, 32'h100, 1'b1, 1'b0); tick();
        set_upd(1'b0, '0, 1'b0, 1'b0);
        #1;
        check("model_ctr_st",   m64[0], 3);
        check("taken_pc_pred",  pc_pred64, 32'hF8);
        check("taken_pred",     pred_taken64, 1);

        pc = 32'h200;
        #1;
        check("alias64_pc_pred",  pc_pred64, 32'h1F8);
        check("alias128_pc_pred", pc_pred128, 32'h204);
        check("alias128_taken",   pred_taken128, 0);
        tick();

        pc = 32'h100;
        for (int i = 0; i < 4; i++) begin
            set_upd(1'b1, 32'h100, 1'b0, 1'b1);
            tick();
        end
        set_upd(1'b1, 32'h100, 1'b1, 1'b0); tick();
        set_upd(1'b0, '0, 1'b0, 1'b0);
        #1;
        check("model_ctr_after_sat", m64[0], 1);
        check("sat_hold_pc_pred",    pc_pred64, 32'h104);

        set_upd(1'b1, 32'h100, 1'b1, 1'b1);
        #1;
        check("same_cycle_old_pc_pred", pc_pred64, 32'h104);
        check("same_cycle_old_taken",   pred_taken64, 0);
        tick();
        set_upd(1'b0, '0, 1'b0, 1'b0);
        #1;
        check("same_cycle_new_pc_pred", pc_pred64, 32'hF8);

        pc = 32'h1000; instruction = JAL_800;
        #1;
        check("jal_pc_pred", pc_pred64, 32'h1800);
        check("jal_taken",   pred_taken64, 1);
        flush_flag = 1'b1; flush_addr = 32'h2000;
        #1;
        check("flush_pc_pred", pc_pred64, 32'h2000);
        check("flush_taken",   pred_taken64, 1);
        tick();
        flush_flag = 1'b0;

        for (int i = 0; i < 6; i++) begin
            pc = tbl_pc[i]; instruction = tbl_ins[i];
            set_upd(1'(i % 2), 32'h300 + 32'(i * 4), 1'(i % 3 == 0), 1'b0);
            tick();
        end
        set_upd(1'b0, '0, 1'b0, 1'b0);
        pc = 32'h0; instruction = 32'hFFDFF06F;
        #1;
        check("jal_wrap_pc_pred", pc_pred64, 32'hFFFF_FFFC);
        tick();

        rst_n = 1'b0;
        #1;
        check("stat_reset_br", stat_br64, 0);
        tick();
        rst_n = 1'b1;
        set_upd(1'b0, 32'h104, 1'b1, 1'b1); tick();
        for (int i = 0; i < 5; i++) begin
            set_upd(1'b1, 32'h104 + 32'(i * 4), 1'(i % 2), 1'(i == 0 || i == 2));
            tick();
        end
        set_upd(1'b0, '0, 1'b0, 1'b0);
        #1;
        check("stat_branches_5", stat_br64, 5);
        check("stat_mispreds_2", stat_mp64, 2);
        #1 rst_n = 1'b0;
        #1;
        check("stat_async_br", stat_br64, 0);
        check("stat_async_mp", stat_mp64, 0);
        tick();
        pc = 32'h100; instruction = BR_M8;
        set_upd(1'b1, 32'h100, 1'b1, 1'b1);
        tick();
        rst_n = 1'b1;
        tick();
        set_upd(1'b0, '0, 1'b0, 1'b0);
        #1;
        check("post_reset_br", stat_br64, 1);
        tick();
        tick();

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dyn_bpu.md
DYN_BPU -- requirements
Module: dyn_bpu

Interface
REQ-001 SHALL have parameter XLEN, default 32, instruction/address width.
REQ-002 SHALL have parameter BHT_DEPTH, default 64, number of 2-bit counters; power of two, 4..1024.
REQ-003 SHALL have parameter BHT_INIT, default 2'b01, counter reset state (weakly not-taken).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port pc  input  XLEN  PC of the fetched instruction.
REQ-007 SHALL have port instruction  input  XLEN  fetched instruction word.
REQ-008 SHALL have port flush_flag  input  1  pipeline flush request.
REQ-009 SHALL have port flush_addr  input  XLEN  redirect target on flush.
REQ-010 SHALL have port upd_valid  input  1  EX-stage resolved conditional branch this cycle.
REQ-011 SHALL have port upd_pc  input  XLEN  PC of the resolved branch.
REQ-012 SHALL have port upd_taken  input  1  actual branch outcome.
REQ-013 SHALL have port upd_mispred  input  1  resolved prediction was wrong (qualified by upd_valid).
REQ-014 SHALL have port pc_pred  output  XLEN  predicted next PC.
REQ-015 SHALL have port pred_taken  output  1  branch/jump predicted taken.
REQ-016 SHALL have port stat_branches  output  32  count of resolved branches.
REQ-017 SHALL have port stat_mispreds  output  32  count of mispredictions.

Function
REQ-018 SHALL decode jal as opcode OPCODE_JAL and conditional branch as OPCODE_BREACH; all other opcodes are non-control.
REQ-019 SHALL form immediates: JAL {sign x12, ins[19:12], ins[20], ins[30:21], 0}; branch {sign x20, ins[7], ins[30:25], ins[11:8], 0}; otherwise zero.
REQ-020 SHALL index the BHT with pc[log2(BHT_DEPTH)+1:2] for prediction and upd_pc[same bits] for update.
REQ-021 SHALL compute pc_pred combinationally, priority: flush_flag -> flush_addr; JAL -> pc+imm; branch with counter[1]=1 -> pc+imm; else pc+4; addition modulo 2^XLEN.
REQ-022 SHALL drive pred_taken=1 for JAL or branch with counter[1]=1, 0 otherwise, including during flush (flush does not mask pred_taken).
REQ-023 SHALL update the indexed counter on the clock edge when upd_valid=1: taken increments, not-taken decrements, saturating at 2'b11 and 2'b00.
REQ-024 SHALL ignore upd_taken and upd_mispred when upd_valid=0.
REQ-025 SHALL, when prediction index equals update index in the same cycle, predict from the pre-update counter value (no bypass); new value visible next cycle.
REQ-026 SHALL increment stat_branches on each upd_valid=1 cycle and stat_mispreds on each upd_valid=1 and upd_mispred=1 cycle; both saturate at 32'hFFFF_FFFF.
REQ-027 SHALL have zero-cycle prediction latency and one-cycle update latency.
REQ-028 SHALL keep JAL prediction independent of BHT contents; JAL never updates the BHT.

Reset
REQ-029 SHALL, while rst_n=0, set every counter to BHT_INIT and both stat counters to 0, asynchronously.
REQ-030 SHALL drop an update coincident with reset assertion; first update takes effect on the first edge with rst_n=1.
REQ-031 SHALL produce valid pc_pred during reset (combinational from reset-state counters: branches predict pc+4).

Structure
REQ-032 SHALL take OPCODE_JAL, OPCODE_BREACH, XLEN, ZERO_32BIT and counter encodings (SNT=00, WNT=01, WT=10, ST=11) from the shared config include.
REQ-033 SHALL implement the counter array as one sub-module bpu_bht (read port, write port, async reset); decode, immediates and stats in dyn_bpu.

Verification
REQ-034 SHALL test: reset, branch imm=-8 at pc=0x100 -> pc_pred=0x104, pred_taken=0.
REQ-035 SHALL test: two updates taken at pc=0x100 -> counter 11; fetch -> pc_pred=0xF8; three not-taken -> 00, saturation held on fourth.
REQ-036 SHALL test: JAL imm=+0x800 at pc=0x1000 -> pc_pred=0x1800 regardless of BHT; flush_flag=1, flush_addr=0x2000 same cycle -> pc_pred=0x2000.
REQ-037 SHALL test: update and predict same index same cycle -> prediction uses old counter; next cycle new counter.
REQ-038 SHALL test: aliasing pc=0x100 and 0x200 (BHT_DEPTH=64) share counter; BHT_DEPTH=128 separates them.
REQ-039 SHALL test: 5 updates with 2 mispred -> stat_branches=5, stat_mispreds=2; rst_n pulse mid-run -> both 0 immediately.
